// File: rtl/nbcac_seq_encoder.sv
// Sequential NBCAC (Fibonacci-numeral) crosstalk-avoidance encoder, STEP wire decisions per cycle.
// Optional input range check enabled by defining NBCAC_RANGE_CHECK_EN.
module nbcac_seq_encoder #(
   parameter int DATA_W = 11,
   parameter int WIRES  = 16,
   parameter int STEP   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIRES-1:0]  out_code,
   output logic              out_err
);

   // Weight s_k built top-down: s_WIRES = s_(WIRES-1) = 2, then Fibonacci-like growth.
   function automatic int weight(input int k);
      int s_a;
      int s_b;
      int s_c;
      if (k == 1) return 1;
      if (k >= WIRES - 1) return 2;
      s_a = 2;
      s_b = 2;
      for (int i = WIRES - 2; i >= k; i--) begin
         s_c = s_a + s_b;
         s_b = s_a;
         s_a = s_c;
      end
      return s_a;
   endfunction

   function automatic int vmax_calc();
      int acc;
      acc = 0;
      for (int k = 1; k <= WIRES; k++) acc += weight(k);
      return acc;
   endfunction

   localparam int V_MAX = vmax_calc();
   localparam int VB    = $clog2(V_MAX + 1);
   localparam int R_W   = (DATA_W > VB) ? DATA_W : VB;
   localparam int KW    = $clog2(WIRES + STEP + 1);
   localparam int IW    = $clog2(WIRES);
   localparam int TW    = $clog2(WIRES * R_W);

   function automatic logic [WIRES*R_W-1:0] build_tab();
      logic [WIRES*R_W-1:0] tab;
      tab = '0;
      for (int k = 1; k <= WIRES; k++) tab[(k-1)*R_W +: R_W] = R_W'(weight(k));
      return tab;
   endfunction

   localparam logic [WIRES*R_W-1:0] S_TAB = build_tab();

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [R_W-1:0]   r_q;
   logic [R_W-1:0]   r_nxt;
   logic [R_W-1:0]   r_w;
   logic [R_W-1:0]   s_lo;
   logic [R_W-1:0]   s_hi;
   logic [R_W-1:0]   in_ext;
   logic [KW-1:0]    k_q;
   logic [KW-1:0]    k_nxt;
   logic [WIRES-1:0] d_q;
   logic [WIRES-1:0] d_nxt;
   logic [WIRES-1:0] code_q;
   logic [WIRES-1:0] code_load;
   logic             dk;
   logic             done_entry;

   assign in_ext     = R_W'(in_data);
   assign out_code   = code_q;
   assign done_entry = (state_q == RUN) && (state_nxt == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      r_nxt     = r_q;
      k_nxt     = k_q;
      d_nxt     = d_q;
      r_w       = r_q;
      s_lo      = '0;
      s_hi      = '0;
      dk        = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               d_nxt     = '0;
               d_nxt[0]  = in_data[0];
               r_nxt     = in_ext - R_W'(in_data[0]);
               k_nxt     = KW'(2);
               state_nxt = RUN;
            end
         end
         RUN: begin
            // Decisions in the window chain through d_nxt so a hold sees this cycle's earlier result.
            for (int p = 2; p < WIRES; p++) begin
               if ((p >= int'(k_q)) && (p < int'(k_q) + STEP)) begin
                  s_lo = S_TAB[TW'((p-1)*R_W) +: R_W];
                  s_hi = S_TAB[TW'(p*R_W) +: R_W];
                  if ({1'b0, r_w} >= ({1'b0, s_lo} + {1'b0, s_hi})) dk = 1'b1;
                  else if (r_w < s_lo)                               dk = 1'b0;
                  else                                               dk = d_nxt[IW'(p-2)];
                  d_nxt[IW'(p-1)] = dk;
                  if (dk) r_w = r_w - s_lo;
               end
            end
            if (int'(k_q) + STEP > WIRES) begin
               d_nxt[WIRES-1] = (r_w != '0);
               state_nxt      = DONE;
            end
            r_nxt = r_w;
            k_nxt = k_q + KW'(STEP);
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef NBCAC_RANGE_CHECK_EN
   logic err_pend_q;
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if ((state_q == IDLE) && in_valid) err_pend_q <= (in_ext > R_W'(V_MAX));
         if (done_entry)                    err_q      <= err_pend_q;
      end
   end

   assign code_load = err_pend_q ? '0 : d_nxt;
   assign out_err   = err_q;
`else
   assign code_load = d_nxt;
   assign out_err   = 1'b0;
`endif

   // Only the completed codeword reaches the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '0;
         k_q    <= '0;
         d_q    <= '0;
         code_q <= '0;
      end else begin
         r_q <= r_nxt;
         k_q <= k_nxt;
         d_q <= d_nxt;
         if (done_entry) code_q <= code_load;
      end
   end

endmodule

// File: tb/tb_nbcac_seq_encoder.sv
// Self-checking bench: STEP=1 (DATA_W=11) and STEP=4 (DATA_W=12) encoders against a rule-level model.
module tb_nbcac_seq_encoder;

   localparam int NA   = 15;
   localparam int NB   = 4;
   localparam int VMAX = 3193;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
   logic [10:0] a_in_data;
   logic [15:0] a_out_code;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
   logic [11:0] b_in_data;
   logic [15:0] b_out_code;

   int n_tests = 0;
   int n_fail  = 0;

   int          ma_ph = 0, ma_cnt = 0, ma_val = 0;
   logic [15:0] ma_code = '0;
   logic        ma_err = 1'b0;
   int          mb_ph = 0, mb_cnt = 0, mb_val = 0;
   logic [15:0] mb_code = '0;
   logic        mb_err = 1'b0;

   always #5 clk = ~clk;

   nbcac_seq_encoder #(.DATA_W(11), .WIRES(16), .STEP(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_code(a_out_code), .out_err(a_out_err)
   );

   nbcac_seq_encoder #(.DATA_W(12), .WIRES(16), .STEP(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_code(b_out_code), .out_err(b_out_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Greedy-with-hold decision chain over the 16 Fibonacci-like weights.
   function automatic logic [15:0] encode(input int v);
      int          w [1:16];
      int          r;
      logic [15:0] d;
      w[16] = 2;
      w[15] = 2;
      for (int k = 14; k >= 2; k--) w[k] = w[k+1] + w[k+2];
      w[1] = 1;
      d    = '0;
      d[0] = (v % 2) == 1;
      r    = v - (v % 2);
      for (int k = 2; k <= 15; k++) begin
         if (r >= w[k] + w[k+1]) d[k-1] = 1'b1;
         else if (r < w[k])      d[k-1] = 1'b0;
         else                    d[k-1] = d[k-2];
         if (d[k-1]) r = r - w[k];
      end
      d[15] = (r != 0);
      return d;
   endfunction

   function automatic logic exp_err(input int v);
      logic e;
      e = (v > VMAX);
`ifndef NBCAC_RANGE_CHECK_EN
      e = 1'b0;
`endif
      return e;
   endfunction

   function automatic logic [15:0] exp_code(input int v);
      return exp_err(v) ? 16'h0000 : encode(v);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_ph <= 0; ma_cnt <= 0; ma_code <= '0; ma_err <= 1'b0;
      end else begin
         case (ma_ph)
            0: if (a_in_valid) begin ma_ph <= 1; ma_cnt <= 0; ma_val <= int'(a_in_data); end
            1: begin
               ma_cnt <= ma_cnt + 1;
               if (ma_cnt + 1 == NA) begin
                  ma_ph <= 2; ma_code <= exp_code(ma_val); ma_err <= exp_err(ma_val);
               end
            end
            default: if (a_out_ready) ma_ph <= 0;
         endcase
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mb_ph <= 0; mb_cnt <= 0; mb_code <= '0; mb_err <= 1'b0;
      end else begin
         case (mb_ph)
            0: if (b_in_valid) begin mb_ph <= 1; mb_cnt <= 0; mb_val <= int'(b_in_data); end
            1: begin
               mb_cnt <= mb_cnt + 1;
               if (mb_cnt + 1 == NB) begin
                  mb_ph <= 2; mb_code <= exp_code(mb_val); mb_err <= exp_err(mb_val);
               end
            end
            default: if (b_out_ready) mb_ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("a_in_ready",  32'(a_in_ready),  32'(ma_ph == 0));
      chk("a_out_valid", 32'(a_out_valid), 32'(ma_ph == 2));
      chk("a_out_code",  32'(a_out_code),  32'(ma_code));
      chk("a_out_err",   32'(a_out_err),   32'(ma_err));
      chk("b_in_ready",  32'(b_in_ready),  32'(mb_ph == 0));
      chk("b_out_valid", 32'(b_out_valid), 32'(mb_ph == 2));
      chk("b_out_code",  32'(b_out_code),  32'(mb_code));
      chk("b_out_err",   32'(b_out_err),   32'(mb_err));
   end

   task automatic wait_ready(input bit sel, input string nm);
      int n;
      n = 0;
      while (!(sel ? b_in_ready : a_in_ready) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_rdy"}, 32'(sel ? b_in_ready : a_in_ready), 32'd1);
   endtask

   task automatic send(input bit sel, input int v, input int lat, input logic [15:0] exp,
                       input string nm);
      int n;
      wait_ready(sel, nm);
      if (sel) begin b_in_valid = 1'b1; b_in_data = 12'(v); end
      else     begin a_in_valid = 1'b1; a_in_data = 11'(v); end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      n = 0;
      while (!(sel ? b_out_valid : a_out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_lat"},  32'(n), 32'(lat));
      chk({nm, "_code"}, 32'(sel ? b_out_code : a_out_code), 32'(exp));
   endtask

   initial begin
      int v;
      int dir [5] = '{2047, 1220, 1221, 753, 1974};
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_a_ready", 32'(a_in_ready),  32'd1);
      chk("rst_a_valid", 32'(a_out_valid), 32'd0);
      chk("rst_a_code",  32'(a_out_code),  32'd0);
      chk("rst_a_err",   32'(a_out_err),   32'd0);
      chk("rst_b_ready", 32'(b_in_ready),  32'd1);

      chk("model_0",    32'(encode(0)),    32'h0000);
      chk("model_4",    32'(encode(4)),    32'hC000);
      chk("model_3193", 32'(encode(3193)), 32'hFFFF);

      send(0, 0, NA, 16'h0000, "a_zero");
      send(0, 1, NA, 16'h0001, "a_one");
      send(0, 2, NA, 16'h8000, "a_two");
      send(0, 3, NA, 16'h8001, "a_three");
      send(0, 4, NA, 16'hC000, "a_four");

      send(1, 3193, NB, 16'hFFFF, "b_max");
      send(1, 4,    NB, 16'hC000, "b_hold");
`ifdef NBCAC_RANGE_CHECK_EN
      send(1, 3194, NB, 16'h0000, "b_over");
      chk("b_over_err", 32'(b_out_err), 32'd1);
`endif

      foreach (dir[i]) begin
         send(0, dir[i], NA, exp_code(dir[i]), "a_dir");
         send(1, dir[i], NB, exp_code(dir[i]), "b_dir");
      end
      for (int i = 0; i < 12; i++) begin
         v = int'($urandom_range(0, 2047));
         send(0, v, NA, exp_code(v), "a_sweep");
         send(1, v, NB, exp_code(v), "b_sweep");
      end

      // Backpressure: hold DONE, offer a competing word that must be ignored.
      a_out_ready = 1'b0;
      send(0, 9, NA, encode(9), "a_bp");
      a_in_valid = 1'b1;
      a_in_data  = 11'd3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(a_out_valid), 32'd1);
         chk("bp_ready", 32'(a_in_ready),  32'd0);
         chk("bp_code",  32'(a_out_code),  32'(encode(9)));
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", 32'(a_in_ready), 32'd1);
      send(0, 6, NA, encode(6), "a_after_bp");

      // Abort a word mid-encode with reset.
      wait_ready(0, "a_abort");
      a_in_valid = 1'b1;
      a_in_data  = 11'd100;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", 32'(a_in_ready),  32'd1);
      chk("abort_valid", 32'(a_out_valid), 32'd0);
      chk("abort_code",  32'(a_out_code),  32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", 32'(a_out_valid), 32'd0);
      end
      send(0, 100, NA, encode(100), "a_after_rst");
      send(1, 100, NB, encode(100), "b_after_rst");

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end

endmodule
